// File: rtl/reg_file_16_pkg.sv
// reg_file_16_pkg: register-file geometry shared by the register file, decode and hazard logic.
package reg_file_16_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS = 16;
    localparam int DEF_WIDTH = 16;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    localparam reg_addr_t R0_IDX = '0;
endpackage

// File: rtl/reg_file_16_read_port.sv
// reg_read_port: 16:1 word select with R0 forced to zero.
// Optional write-through bypass when REGFILE_BYPASS_EN is defined.
module reg_read_port
    import reg_file_16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]    i_regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] i_busy,
    input  reg_addr_t           i_raddr,
    input  logic                i_we,
    input  reg_addr_t           i_waddr,
    input  logic [WIDTH-1:0]    i_wdata,
    input  logic                i_issue,
    input  reg_addr_t           i_issue_addr,
    output logic [WIDTH-1:0]    o_rdata,
    output logic                o_busy
);
    logic w_r0;
    assign w_r0 = (i_raddr == R0_IDX);
`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    assign w_hit   = i_we && (i_waddr == i_raddr) && !w_r0;
    // A same-cycle issue to this register is a newer producer, so it stays busy.
    assign o_rdata = w_r0 ? '0 : (w_hit ? i_wdata : i_regs[i_raddr]);
    assign o_busy  = w_r0 ? 1'b0 : (w_hit ? (i_issue && (i_issue_addr == i_raddr)) : i_busy[i_raddr]);
`else
    logic w_unused;
    assign w_unused = ^{i_we, i_waddr, i_wdata, i_issue, i_issue_addr};
    assign o_rdata  = w_r0 ? '0 : i_regs[i_raddr];
    assign o_busy   = w_r0 ? 1'b0 : i_busy[i_raddr];
`endif
endmodule

// File: rtl/reg_file_16.sv
// reg_file_16: 16-entry 1W/2R register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for write-through forwarding to both read ports.
module reg_file_16
    import reg_file_16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  reg_addr_t        i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_issue,
    input  reg_addr_t        i_issue_addr,
    input  reg_addr_t        i_raddr_a,
    input  reg_addr_t        i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b,
    output logic             o_busy_a,
    output logic             o_busy_b
);
    logic [WIDTH-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_we_fwd;

    // Issue is applied after write-back so the newer producer wins on a collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_we) w_busy_nxt[i_waddr] = 1'b0;
        if (i_issue) w_busy_nxt[i_issue_addr] = 1'b1;
        w_busy_nxt[R0_IDX] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_regs <= '{default: '0};
            r_busy <= '0;
        end else begin
            if (i_we && i_waddr != R0_IDX) r_regs[i_waddr] <= i_wdata;
            r_busy <= w_busy_nxt;
        end
    end

    // Forwarding is suppressed during reset so outputs read zero.
    assign w_we_fwd = i_we && !i_rst;

    reg_read_port #(.WIDTH(WIDTH)) u_port_a (
        .i_regs(r_regs), .i_busy(r_busy), .i_raddr(i_raddr_a),
        .i_we(w_we_fwd), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_issue(i_issue), .i_issue_addr(i_issue_addr),
        .o_rdata(o_rdata_a), .o_busy(o_busy_a)
    );

    reg_read_port #(.WIDTH(WIDTH)) u_port_b (
        .i_regs(r_regs), .i_busy(r_busy), .i_raddr(i_raddr_b),
        .i_we(w_we_fwd), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_issue(i_issue), .i_issue_addr(i_issue_addr),
        .o_rdata(o_rdata_b), .o_busy(o_busy_b)
    );
endmodule

// File: tb/tb_reg_file_16.sv
// tb_reg_file_16: directed scoreboard bench for reg_file_16 (honours REGFILE_BYPASS_EN).
module tb_reg_file_16;
    import reg_file_16_pkg::*;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, we = 1'b0, issue = 1'b0;
    reg_addr_t waddr = '0, iaddr = '0, ra = '0, rb = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rda, rdb;
    logic bsa, bsb;
    typedef struct {
        string tag;
        logic [15:0] ea;
        logic [15:0] eb;
        logic ba;
        logic bb;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    reg_file_16 #(.WIDTH(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_issue(issue), .i_issue_addr(iaddr), .i_raddr_a(ra), .i_raddr_b(rb),
        .o_rdata_a(rda), .o_rdata_b(rdb), .o_busy_a(bsa), .o_busy_b(bsb)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic w, input reg_addr_t wa, input logic [15:0] wd,
                         input logic is, input reg_addr_t ia, input reg_addr_t a, input reg_addr_t b);
        we = w; waddr = wa; wdata = wd; issue = is; iaddr = ia; ra = a; rb = b;
    endtask

    task automatic push_exp(input string t, input logic [15:0] ea, input logic [15:0] eb,
                            input logic ba, input logic bb);
        exp_t e;
        e.tag = t; e.ea = ea; e.eb = eb; e.ba = ba; e.bb = bb;
        q.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        #1;
        n_cmp++;
        assert (q.size() != 0) else begin
            n_bad++;
            $error("FAIL scoreboard_empty observed 0 entries expected >=1");
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            n_cmp++;
            assert (rda === e.ea) else begin
                n_bad++;
                $error("FAIL %s rdata_a observed %h expected %h", e.tag, rda, e.ea);
            end
            n_cmp++;
            assert (rdb === e.eb) else begin
                n_bad++;
                $error("FAIL %s rdata_b observed %h expected %h", e.tag, rdb, e.eb);
            end
            n_cmp++;
            assert (bsa === e.ba) else begin
                n_bad++;
                $error("FAIL %s busy_a observed %b expected %b", e.tag, bsa, e.ba);
            end
            n_cmp++;
            assert (bsb === e.bb) else begin
                n_bad++;
                $error("FAIL %s busy_b observed %b expected %b", e.tag, bsb, e.bb);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        push_exp("rst_init", 16'h0, 16'h0, 1'b0, 1'b0); compare();
        @(negedge clk); rst = 1'b0;
        drive(1, 4'd5, 16'h1234, 0, 4'd0, 4'd5, 4'd0);
        push_exp("w5_same", BYP ? 16'h1234 : 16'h0000, 16'h0, 1'b0, 1'b0); compare();
        step();
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd5, 4'd0);
        push_exp("r5", 16'h1234, 16'h0, 1'b0, 1'b0); compare();
        #1; rst = 1'b1;
        push_exp("rst_async", 16'h0, 16'h0, 1'b0, 1'b0); compare();
        drive(1, 4'd5, 16'hAAAA, 0, 4'd0, 4'd5, 4'd5);
        push_exp("rst_fwd_gate", 16'h0, 16'h0, 1'b0, 1'b0); compare();
        @(negedge clk); rst = 1'b0;
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd5, 4'd0);
        push_exp("rst_hold", 16'h0, 16'h0, 1'b0, 1'b0); compare();
        drive(1, 4'd0, 16'hFFFF, 1, 4'd0, 4'd0, 4'd0);
        push_exp("r0_same", 16'h0, 16'h0, 1'b0, 1'b0); compare();
        step();
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd0, 4'd0);
        push_exp("r0_after", 16'h0, 16'h0, 1'b0, 1'b0); compare();
        drive(1, 4'd3, 16'hBEEF, 0, 4'd0, 4'd3, 4'd3);
        push_exp("w3_same", BYP ? 16'hBEEF : 16'h0, BYP ? 16'hBEEF : 16'h0, 1'b0, 1'b0); compare();
        step();
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd3, 4'd3);
        push_exp("r3", 16'hBEEF, 16'hBEEF, 1'b0, 1'b0); compare();
        drive(0, 4'd0, 16'h0, 1, 4'd7, 4'd3, 4'd7);
        push_exp("iss7_same", 16'hBEEF, 16'h0, 1'b0, 1'b0); compare();
        step();
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd3, 4'd7);
        push_exp("busy7", 16'hBEEF, 16'h0, 1'b0, 1'b1); compare();
        step();
        push_exp("busy7_hold", 16'hBEEF, 16'h0, 1'b0, 1'b1); compare();
        drive(1, 4'd7, 16'h00A5, 0, 4'd0, 4'd3, 4'd7);
        push_exp("w7_same", 16'hBEEF, BYP ? 16'h00A5 : 16'h0, 1'b0, !BYP); compare();
        step();
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd3, 4'd7);
        push_exp("w7_after", 16'hBEEF, 16'h00A5, 1'b0, 1'b0); compare();
        drive(0, 4'd0, 16'h0, 1, 4'd9, 4'd0, 4'd9);
        step();
        drive(1, 4'd9, 16'h1111, 1, 4'd9, 4'd0, 4'd9);
        push_exp("wi9_same", 16'h0, BYP ? 16'h1111 : 16'h0, 1'b0, 1'b1); compare();
        step();
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd7, 4'd9);
        push_exp("wi9_after", 16'h00A5, 16'h1111, 1'b0, 1'b1); compare();
        drive(1, 4'd4, 16'h0F0F, 0, 4'd0, 4'd0, 4'd0);
        step();
        drive(0, 4'd0, 16'h0, 1, 4'd4, 4'd4, 4'd0);
        push_exp("iss4_same", 16'h0F0F, 16'h0, 1'b0, 1'b0); compare();
        step();
        drive(1, 4'd4, 16'h5A5A, 0, 4'd0, 4'd4, 4'd3);
        push_exp("byp4", BYP ? 16'h5A5A : 16'h0F0F, 16'hBEEF, !BYP, 1'b0); compare();
        step();
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd4, 4'd3);
        push_exp("byp4_after", 16'h5A5A, 16'hBEEF, 1'b0, 1'b0); compare();
        drive(0, 4'd0, 16'h0, 1, 4'd11, 4'd4, 4'd11);
        step();
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd4, 4'd11);
        push_exp("busy11", 16'h5A5A, 16'h0, 1'b0, 1'b1); compare();
        #1; rst = 1'b1;
        push_exp("rst_busy", 16'h0, 16'h0, 1'b0, 1'b0); compare();
        @(negedge clk); rst = 1'b0;
        push_exp("post_rst", 16'h0, 16'h0, 1'b0, 1'b0); compare();
        drive(0, 4'd0, 16'h0, 1, 4'd11, 4'd4, 4'd11);
        step();
        drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd4, 4'd11);
        push_exp("post_rst_issue", 16'h0, 16'h0, 1'b0, 1'b1); compare();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
